// File: rtl/exec_stage_pkg.sv
// Shared widths and load/store size codes for the KCP53K execute stage.
package exec_stage_pkg;
   localparam int XLEN = 64;
   localparam int REGW = 5;
   localparam int XRSW = 3;

   typedef enum logic [XRSW-1:0] {
      XRS_NONE = 3'd0,
      XRS_S8   = 3'd1,
      XRS_S16  = 3'd2,
      XRS_S32  = 3'd3,
      XRS_S64  = 3'd4,
      XRS_U8   = 3'd5,
      XRS_U16  = 3'd6,
      XRS_U32  = 3'd7
   } xrs_rwe_e;
endpackage

// File: rtl/exec_stage_alu.sv
// Combinational ALU: every unit evaluates in parallel, enables gate an OR-merge.
module exec_alu
   import exec_stage_pkg::*;
(
   input  logic [XLEN-1:0] inpa,
   input  logic [XLEN-1:0] inpb,
   input  logic            invb,
   input  logic            cflag,
   input  logic            lsh_en,
   input  logic            rsh_en,
   input  logic            ltu_en,
   input  logic            lts_en,
   input  logic            sum_en,
   input  logic            and_en,
   input  logic            xor_en,
   output logic [XLEN-1:0] result
);
   logic [5:0]      amt;
   logic [XLEN-1:0] b_eff;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] lsh;
   logic [XLEN-1:0] rsh;
   logic [XLEN-1:0] ltu;
   logic [XLEN-1:0] lts;

   assign amt   = inpb[5:0];
   assign b_eff = invb ? ~inpb : inpb;
   assign sum   = inpa + b_eff + {{(XLEN-1){1'b0}}, cflag};
   assign lsh   = inpa << amt;
   // cflag doubles as the arithmetic/logical selector for right shifts
   assign rsh   = cflag ? $unsigned($signed(inpa) >>> amt) : (inpa >> amt);
   assign ltu   = {{(XLEN-1){1'b0}}, (inpa < inpb)};
   assign lts   = {{(XLEN-1){1'b0}}, ($signed(inpa) < $signed(inpb))};

   assign result = ({XLEN{sum_en}} & sum)
                 | ({XLEN{and_en}} & (inpa & inpb))
                 | ({XLEN{xor_en}} & (inpa ^ inpb))
                 | ({XLEN{lsh_en}} & lsh)
                 | ({XLEN{rsh_en}} & rsh)
                 | ({XLEN{ltu_en}} & ltu)
                 | ({XLEN{lts_en}} & lts);
endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU plus the single pipeline register toward the memory stage.
module exec_stage
   import exec_stage_pkg::*;
(
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [XLEN-1:0] inpa_i,
   input  logic [XLEN-1:0] inpb_i,
   input  logic            invB_i,
   input  logic            cflag_i,
   input  logic            lsh_en_i,
   input  logic            rsh_en_i,
   input  logic            ltu_en_i,
   input  logic            lts_en_i,
   input  logic            sum_en_i,
   input  logic            and_en_i,
   input  logic            xor_en_i,
   input  logic [REGW-1:0] rd_i,
   input  logic            we_i,
   input  logic            nomem_i,
   input  logic            mem_i,
   input  logic [XLEN-1:0] dat_i,
   input  logic [XRSW-1:0] xrs_rwe_i,
   input  logic            busy_i,
   output logic [REGW-1:0] rd_o,
   output logic [XLEN-1:0] addr_o,
   output logic            we_o,
   output logic            nomem_o,
   output logic            mem_o,
   output logic [XLEN-1:0] dat_o,
   output logic [XRSW-1:0] xrs_rwe_o
);
   logic [XLEN-1:0] result;

   exec_alu u_alu (
      .inpa   (inpa_i),
      .inpb   (inpb_i),
      .invb   (invB_i),
      .cflag  (cflag_i),
      .lsh_en (lsh_en_i),
      .rsh_en (rsh_en_i),
      .ltu_en (ltu_en_i),
      .lts_en (lts_en_i),
      .sum_en (sum_en_i),
      .and_en (and_en_i),
      .xor_en (xor_en_i),
      .result (result)
   );

   // Stall freezes the whole register; upstream holds its operands meanwhile.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rd_o      <= '0;
         addr_o    <= '0;
         we_o      <= 1'b0;
         nomem_o   <= 1'b0;
         mem_o     <= 1'b0;
         dat_o     <= '0;
         xrs_rwe_o <= '0;
      end else if (!busy_i) begin
         rd_o      <= rd_i;
         addr_o    <= result;
         we_o      <= we_i;
         nomem_o   <= nomem_i;
         mem_o     <= mem_i;
         dat_o     <= dat_i;
         xrs_rwe_o <= xrs_rwe_i;
      end
   end
endmodule

// File: tb/tb_exec_stage.sv
// Directed vectors feed a scoreboard queue; a monitor pops and compares one cycle later.
module tb_exec_stage;
   import exec_stage_pkg::*;

   localparam logic [6:0] EN_NONE = 7'b0000000;
   localparam logic [6:0] EN_XOR  = 7'b0000001;
   localparam logic [6:0] EN_AND  = 7'b0000010;
   localparam logic [6:0] EN_SUM  = 7'b0000100;
   localparam logic [6:0] EN_LTS  = 7'b0001000;
   localparam logic [6:0] EN_LTU  = 7'b0010000;
   localparam logic [6:0] EN_RSH  = 7'b0100000;
   localparam logic [6:0] EN_LSH  = 7'b1000000;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [63:0] inpa_i, inpb_i, dat_i;
   logic        invB_i, cflag_i;
   logic        lsh_en_i, rsh_en_i, ltu_en_i, lts_en_i, sum_en_i, and_en_i, xor_en_i;
   logic [4:0]  rd_i;
   logic        we_i, nomem_i, mem_i, busy_i;
   logic [2:0]  xrs_rwe_i;
   logic [4:0]  rd_o;
   logic [63:0] addr_o, dat_o;
   logic        we_o, nomem_o, mem_o;
   logic [2:0]  xrs_rwe_o;

   exec_stage dut (
      .clk_i(clk_i), .reset_i(reset_i), .inpa_i(inpa_i), .inpb_i(inpb_i),
      .invB_i(invB_i), .cflag_i(cflag_i), .lsh_en_i(lsh_en_i), .rsh_en_i(rsh_en_i),
      .ltu_en_i(ltu_en_i), .lts_en_i(lts_en_i), .sum_en_i(sum_en_i),
      .and_en_i(and_en_i), .xor_en_i(xor_en_i), .rd_i(rd_i), .we_i(we_i),
      .nomem_i(nomem_i), .mem_i(mem_i), .dat_i(dat_i), .xrs_rwe_i(xrs_rwe_i),
      .busy_i(busy_i), .rd_o(rd_o), .addr_o(addr_o), .we_o(we_o),
      .nomem_o(nomem_o), .mem_o(mem_o), .dat_o(dat_o), .xrs_rwe_o(xrs_rwe_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] a, b, dat, exp;
      logic        invb, cflag, we, nomem, mem, busy;
      logic [6:0]  en;
      logic [4:0]  rd;
      logic [2:0]  xrs;
   } vec_t;

   typedef struct {
      int          idx;
      int          due;
      logic [63:0] addr, dat;
      logic [4:0]  rd;
      logic        we, nomem, mem;
      logic [2:0]  xrs;
   } exp_t;

   exp_t q[$];
   exp_t last;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic invb,
                               input logic cflag, input logic [6:0] en, input logic [4:0] rd,
                               input logic we, input logic nomem, input logic mem,
                               input logic [63:0] dat, input logic [2:0] xrs,
                               input logic busy, input logic [63:0] exp);
      vec_t v;
      v.a = a; v.b = b; v.invb = invb; v.cflag = cflag; v.en = en; v.rd = rd;
      v.we = we; v.nomem = nomem; v.mem = mem; v.dat = dat; v.xrs = xrs;
      v.busy = busy; v.exp = exp;
      return v;
   endfunction

   task automatic issue(input int idx, input vec_t v);
      exp_t e;
      @(negedge clk_i);
      inpa_i = v.a; inpb_i = v.b; invB_i = v.invb; cflag_i = v.cflag;
      {lsh_en_i, rsh_en_i, ltu_en_i, lts_en_i, sum_en_i, and_en_i, xor_en_i} = v.en;
      rd_i = v.rd; we_i = v.we; nomem_i = v.nomem; mem_i = v.mem;
      dat_i = v.dat; xrs_rwe_i = v.xrs; busy_i = v.busy;
      if (v.busy) begin
         e = last;
      end else begin
         e.addr = v.exp; e.dat = v.dat; e.rd = v.rd; e.we = v.we;
         e.nomem = v.nomem; e.mem = v.mem; e.xrs = v.xrs;
      end
      e.idx = idx;
      e.due = cyc + 1;
      last = e;
      q.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " addr"},  addr_o,    64'd0);
      chk({tag, " rd"},    {59'd0, rd_o}, 64'd0);
      chk({tag, " we"},    {63'd0, we_o}, 64'd0);
      chk({tag, " nomem"}, {63'd0, nomem_o}, 64'd0);
      chk({tag, " mem"},   {63'd0, mem_o}, 64'd0);
      chk({tag, " dat"},   dat_o,     64'd0);
      chk({tag, " xrs"},   {61'd0, xrs_rwe_o}, 64'd0);
   endtask

   // Monitor: registered outputs are sampled 1 ns after each rising edge.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         cyc++;
         while (q.size() != 0 && q[0].due <= cyc) begin
            exp_t e;
            string t;
            e = q.pop_front();
            t = $sformatf("v%0d", e.idx);
            chk({t, " latency"}, 64'(cyc), 64'(e.due));
            chk({t, " addr"},  addr_o, e.addr);
            chk({t, " rd"},    {59'd0, rd_o}, {59'd0, e.rd});
            chk({t, " we"},    {63'd0, we_o}, {63'd0, e.we});
            chk({t, " nomem"}, {63'd0, nomem_o}, {63'd0, e.nomem});
            chk({t, " mem"},   {63'd0, mem_o}, {63'd0, e.mem});
            chk({t, " dat"},   dat_o, e.dat);
            chk({t, " xrs"},   {61'd0, xrs_rwe_o}, {61'd0, e.xrs});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   vec_t vecs[$];

   initial begin
      reset_i = 1'b0;
      inpa_i = 64'h1234; inpb_i = 64'h5678; dat_i = 64'hFFFF; invB_i = 1'b0; cflag_i = 1'b0;
      {lsh_en_i, rsh_en_i, ltu_en_i, lts_en_i, sum_en_i, and_en_i, xor_en_i} = EN_SUM;
      rd_i = 5'd7; we_i = 1'b1; nomem_i = 1'b1; mem_i = 1'b1; xrs_rwe_i = 3'd5; busy_i = 1'b0;
      last = '{default: '0};
      #1 chk_zero("reset");
      repeat (2) @(negedge clk_i);
      reset_i = 1'b1;
      #1 chk_zero("post_release");

      //            a                      b                      ib cf en      rd    we nm mm dat        xrs      bsy exp
      vecs.push_back(mk(64'hE00000,             64'hFFFFFFFFFFFFF800, 0, 0, EN_SUM, 5'd23, 0, 0, 1, 64'h0,    XRS_S16, 0, 64'hDFF800));
      vecs.push_back(mk(64'hE00000,             64'h7FF,              0, 0, EN_SUM, 5'd23, 1, 0, 1, 64'hDEAD, XRS_S16, 0, 64'hE007FF));
      vecs.push_back(mk(64'h400000,             64'hFFFFFFFFFFFFF800, 0, 0, EN_SUM, 5'd19, 0, 0, 1, 64'h0,    XRS_S8,  0, 64'h3FF800));
      vecs.push_back(mk(64'd5,                  64'd7,                1, 1, EN_SUM, 5'd5,  0, 1, 0, 64'h0,    XRS_NONE,0, 64'hFFFFFFFFFFFFFFFE));
      vecs.push_back(mk(64'hFFFFFFFFFFFFFFFF,   64'd1,                0, 0, EN_LTS, 5'd6,  0, 1, 0, 64'h0,    XRS_NONE,0, 64'd1));
      vecs.push_back(mk(64'hFFFFFFFFFFFFFFFF,   64'd1,                0, 0, EN_LTU, 5'd7,  0, 1, 0, 64'h0,    XRS_NONE,0, 64'd0));
      vecs.push_back(mk(64'h8000000000000000,   64'd4,                0, 1, EN_RSH, 5'd8,  0, 1, 0, 64'h0,    XRS_NONE,0, 64'hF800000000000000));
      vecs.push_back(mk(64'h8000000000000000,   64'd4,                0, 0, EN_RSH, 5'd9,  0, 1, 0, 64'h0,    XRS_NONE,0, 64'h0800000000000000));
      vecs.push_back(mk(64'd1,                  64'd63,               0, 0, EN_LSH, 5'd10, 0, 1, 0, 64'h0,    XRS_NONE,0, 64'h8000000000000000));
      vecs.push_back(mk(64'd1,                  64'h41,               0, 0, EN_LSH, 5'd11, 0, 1, 0, 64'h0,    XRS_NONE,0, 64'd2));
      vecs.push_back(mk(64'h4000000000000000,   64'd2,                0, 1, EN_RSH, 5'd12, 0, 1, 0, 64'h0,    XRS_NONE,0, 64'h1000000000000000));
      vecs.push_back(mk(64'hFF00FF00,           64'h0F0F0F0F,         0, 0, EN_AND, 5'd13, 0, 1, 0, 64'h0,    XRS_NONE,0, 64'h0F000F00));
      vecs.push_back(mk(64'hFF00FF00,           64'h0F0F0F0F,         0, 0, EN_XOR, 5'd14, 0, 1, 0, 64'h0,    XRS_NONE,0, 64'hF00FF00F));
      vecs.push_back(mk(64'hFF00FF00,           64'h0F0F0F0F,         0, 0, EN_NONE,5'd15, 0, 1, 0, 64'h0,    XRS_NONE,0, 64'd0));
      vecs.push_back(mk(64'hFFFFFFFFFFFFFFFF,   64'd0,                0, 1, EN_SUM, 5'd16, 0, 1, 0, 64'h0,    XRS_NONE,0, 64'd0));
      vecs.push_back(mk(64'h100,                64'h23,               0, 0, EN_SUM, 5'd31, 1, 0, 1, 64'hCAFE, XRS_U32, 0, 64'h123));
      vecs.push_back(mk(64'h999,                64'h1,                0, 0, EN_SUM, 5'd1,  0, 1, 0, 64'h11,   XRS_S64, 1, 64'h99A));
      vecs.push_back(mk(64'h777,                64'h2,                1, 1, EN_XOR, 5'd2,  1, 0, 1, 64'h22,   XRS_U8,  1, 64'h775));
      vecs.push_back(mk(64'h555,                64'h3,                0, 0, EN_AND, 5'd3,  0, 0, 1, 64'h33,   XRS_U16, 1, 64'h1));
      vecs.push_back(mk(64'h1000,               64'h10,               0, 0, EN_SUM, 5'd4,  0, 1, 0, 64'h44,   XRS_S32, 0, 64'h1010));

      foreach (vecs[i]) issue(i, vecs[i]);
      @(negedge clk_i);
      busy_i = 1'b1;
      inpa_i = 64'hAAAA; dat_i = 64'hBBBB;
      #3 reset_i = 1'b0;
      #1 chk_zero("async_reset");
      @(negedge clk_i);
      chk_zero("reset_held");
      reset_i = 1'b1;
      last = '{default: '0};
      #1 chk_zero("reset_release");
      issue(100, mk(64'h20, 64'h5, 0, 0, EN_SUM, 5'd21, 0, 1, 0, 64'h55, XRS_S8, 0, 64'h25));
      repeat (3) @(negedge clk_i);
      chk("queue drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the 64-bit KCP53K pipelined core.
- Takes decoded operands and control strobes from the decode/register-read stage and computes one ALU result per cycle: sum/difference, AND, XOR, shifts, set-less-than.
- Registers that result, together with the memory/writeback controls, toward the memory stage.
- The ALU result doubles as the effective address for loads and stores.

Parameters:
- None. Data path is fixed at 64 bits; register index at 5 bits; XRS code at 3 bits.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- inpa_i  in  64  operand A.
- inpb_i  in  64  operand B (immediate or register).
- invB_i  in  1  invert B before the adder (subtract).
- cflag_i  in  1  adder carry-in; for right shifts, 1 selects arithmetic, 0 selects logical.
- lsh_en_i  in  1  enable left-shift result.
- rsh_en_i  in  1  enable right-shift result.
- ltu_en_i  in  1  enable unsigned less-than result.
- lts_en_i  in  1  enable signed less-than result.
- sum_en_i  in  1  enable adder result.
- and_en_i  in  1  enable AND result.
- xor_en_i  in  1  enable XOR result.
- rd_i  in  5  destination register index.
- we_i  in  1  memory write (store) request.
- nomem_i  in  1  non-memory op; result goes to writeback.
- mem_i  in  1  memory op; result is the address.
- dat_i  in  64  store data.
- xrs_rwe_i  in  3  load/store size and sign-extension code.
- busy_i  in  1  downstream stall.
- rd_o  out  5  registered rd_i.
- addr_o  out  64  registered ALU result.
- we_o  out  1  registered we_i.
- nomem_o  out  1  registered nomem_i.
- mem_o  out  1  registered mem_i.
- dat_o  out  64  registered dat_i.
- xrs_rwe_o  out  3  registered xrs_rwe_i.

Behaviour:
- Reset: while reset_i=0, every output is 0, asynchronously. Outputs stay 0 until the first rising edge after reset_i returns to 1.
- Adder: B' = invB_i ? ~inpb_i : inpb_i; sum = inpa_i + B' + cflag_i, modulo 2^64, carry-out discarded.
- AND = inpa_i & inpb_i; XOR = inpa_i ^ inpb_i.
- Shift amount = inpb_i[5:0].
  - lsh: inpa_i << amt, zero fill.
  - rsh: inpa_i >> amt, fill with inpa_i[63] if cflag_i=1, else zero fill.
- ltu = {63'b0, inpa_i < inpb_i unsigned}; lts = same with a signed compare. Both are independent of invB_i and cflag_i.
- Result = bitwise OR of each sub-result gated by its enable.
  - No enable asserted: result = 0.
  - Multiple enables: the OR is taken; the decoder guarantees one-hot, so no error checking.
- Pipeline register, latency exactly 1 cycle:
  - On rising edge with busy_i=0: addr_o<=result, rd_o<=rd_i, we_o<=we_i, nomem_o<=nomem_i, mem_o<=mem_i, dat_o<=dat_i, xrs_rwe_o<=xrs_rwe_i.
  - On rising edge with busy_i=1: all outputs hold their current values; inputs are ignored (the upstream stage must hold them).
- Control fields pass through unmodified; the stage does not interpret nomem/mem/we.
- Reset asserted mid-stall clears outputs immediately; reset dominates busy_i.

Decomposition:
- Shared package:
  - XRS_RWE codes (3 bits: none, S8, S16, S32, S64, U8, U16, U32).
  - Width constants XLEN=64, REGW=5.
- Natural sub-module: exec_alu, purely combinational (operands + enables -> 64-bit result).
- The pipeline register stays in exec_stage.

Test Plan:
- Reset then sum, load: inpa=0xE00000, inpb=0xFFFFFFFFFFFFF800, sum_en=1, mem=1, rd=23, xrs=S16, dat=0 -> next cycle addr_o=0xDFF800, rd_o=23, mem_o=1, nomem_o=0, we_o=0, dat_o=0, xrs_rwe_o=S16.
- Store: inpa=0xE00000, inpb=0x7FF, dat=0xDEAD, we=1, mem=1, xrs=S16, rd=23 -> addr_o=0xE007FF, we_o=1, dat_o=0xDEAD, xrs_rwe_o=S16.
- Back-to-back, no bubble: next cycle inpa=0x400000, inpb=0xFFFFFFFFFFFFF800, we=0, rd=19, xrs=S8 -> addr_o=0x3FF800, rd_o=19, we_o=0, xrs_rwe_o=S8.
- Subtract/compare:
  - inpa=5, inpb=7, invB=1, cflag=1, sum_en -> addr_o=0xFFFFFFFFFFFFFFFE.
  - lts_en with inpa=-1, inpb=1 -> addr_o=1.
  - ltu_en with the same operands -> addr_o=0.
- Shifts, inpa=0x8000000000000000, inpb=4:
  - rsh_en, cflag=1 -> addr_o=0xF800000000000000.
  - cflag=0 -> addr_o=0x0800000000000000.
  - lsh_en with inpa=1, inpb=63 -> addr_o=0x8000000000000000.
- Stall and reset:
  - busy_i=1 for 3 cycles with changing inputs -> all outputs hold the prior values.
  - reset_i pulsed low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
